// File: rtl/fp16_div_seq.sv
// fp16_div_seq: sequential IEEE-754 binary16 divider, result = x / y.
// A restoring divider produces one quotient bit per cycle. Subnormal
// operands are flushed to zero and results that would be subnormal are
// flushed to zero as well. Only one operation is in flight at a time.
//
// Ports:
//   clk, reset_n            clock (rising edge), asynchronous active-low reset
//   x, y, roundmode         dividend, divisor, rounding mode
//                           (00 rz, 01 rne, 10 toward +inf, 11 toward -inf)
//   in_valid / in_ready     input handshake; in_ready is high only when idle
//   result, flags           quotient and {nv, dz, of, uf, nx}, both registered
//   out_valid / out_ready   output handshake; the result is held until taken
module fp16_div_seq #(
    parameter int unsigned QBITS = 13,
    parameter int unsigned BIAS  = 15
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] x,
    input  logic [15:0] y,
    input  logic [1:0]  roundmode,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [15:0] result,
    output logic [4:0]  flags,
    output logic        out_valid,
    input  logic        out_ready
);

    typedef enum logic [1:0] {S_IDLE, S_DIV, S_ROUND, S_DONE} state_t;

    localparam logic [3:0] LAST = 4'(QBITS - 1);

    state_t             r_state, w_next;
    logic [3:0]         r_cnt;
    logic [QBITS-1:0]   r_q;
    logic [11:0]        r_rem;
    logic [10:0]        r_my;
    logic signed [6:0]  r_e;
    logic               r_s;
    logic [1:0]         r_rm;
    logic [15:0]        r_result;
    logic [4:0]         r_flags;
    logic               r_out_valid;

    // Operand classification
    logic w_x_zero, w_x_inf, w_x_nan, w_x_snan;
    logic w_y_zero, w_y_inf, w_y_nan, w_y_snan;
    logic w_s, w_accept, w_special;
    logic [15:0] w_sp_res;
    logic [4:0]  w_sp_flags;

    assign w_x_zero = (x[14:10] == 5'd0);
    assign w_x_inf  = (x[14:10] == 5'd31) && (x[9:0] == 10'd0);
    assign w_x_nan  = (x[14:10] == 5'd31) && (x[9:0] != 10'd0);
    assign w_x_snan = w_x_nan && !x[9];
    assign w_y_zero = (y[14:10] == 5'd0);
    assign w_y_inf  = (y[14:10] == 5'd31) && (y[9:0] == 10'd0);
    assign w_y_nan  = (y[14:10] == 5'd31) && (y[9:0] != 10'd0);
    assign w_y_snan = w_y_nan && !y[9];
    assign w_s      = x[15] ^ y[15];
    assign w_accept = in_valid && (r_state == S_IDLE);

    // Special-case results, checked in precedence order
    always_comb begin
        w_special  = 1'b1;
        w_sp_res   = 16'h0000;
        w_sp_flags = 5'b0;
        if (w_x_nan || w_y_nan) begin
            w_sp_res      = 16'h7E00;
            w_sp_flags[4] = w_x_snan || w_y_snan;
        end else if ((w_x_zero && w_y_zero) || (w_x_inf && w_y_inf)) begin
            w_sp_res      = 16'h7E00;
            w_sp_flags[4] = 1'b1;
        end else if (w_x_inf) begin
            w_sp_res = {w_s, 15'h7C00};
        end else if (w_y_zero) begin
            w_sp_res      = {w_s, 15'h7C00};
            w_sp_flags[3] = 1'b1;
        end else if (w_x_zero || w_y_inf) begin
            w_sp_res = {w_s, 15'h0000};
        end else begin
            w_special = 1'b0;
        end
    end

    // Restoring step: after subtraction the remainder is below the divisor,
    // so 11 bits hold it and the shifted value never overflows 12 bits.
    logic        w_ge;
    logic [10:0] w_rem_sub;
    assign w_ge      = (r_rem >= {1'b0, r_my});
    assign w_rem_sub = 11'(r_rem - {1'b0, r_my});

    // Normalise and round
    logic              w_norm, w_g, w_st, w_inc, w_ovf_inf;
    logic [10:0]       w_sig, w_sig_r;
    logic [11:0]       w_sum;
    logic signed [6:0] w_e, w_e_r;
    logic [15:0]       w_rnd_res;
    logic [4:0]        w_rnd_flags;

    always_comb begin
        w_norm = r_q[12];
        if (w_norm) begin
            w_sig = r_q[12:2];
            w_g   = r_q[1];
            w_st  = r_q[0] | (|r_rem);
            w_e   = r_e;
        end else begin
            w_sig = r_q[11:1];
            w_g   = r_q[0];
            w_st  = |r_rem;
            w_e   = r_e - 7'sd1;
        end
        case (r_rm)
            2'b00:   w_inc = 1'b0;
            2'b01:   w_inc = w_g & (w_st | w_sig[0]);
            2'b10:   w_inc = !r_s & (w_g | w_st);
            default: w_inc = r_s & (w_g | w_st);
        endcase
        w_sum = {1'b0, w_sig} + {11'd0, w_inc};
        if (w_sum[11]) begin
            w_sig_r = 11'h400;
            w_e_r   = w_e + 7'sd1;
        end else begin
            w_sig_r = w_sum[10:0];
            w_e_r   = w_e;
        end
        w_ovf_inf = (r_rm == 2'b01) || (r_rm == 2'b10 && !r_s) || (r_rm == 2'b11 && r_s);
        if (w_e_r >= 7'sd31) begin
            w_rnd_res   = w_ovf_inf ? {r_s, 15'h7C00} : {r_s, 15'h7BFF};
            w_rnd_flags = 5'b00101;
        end else if (w_e_r <= 7'sd0) begin
            w_rnd_res   = {r_s, 15'h0000};
            w_rnd_flags = 5'b00011;
        end else begin
            w_rnd_res   = {r_s, w_e_r[4:0], w_sig_r[9:0]};
            w_rnd_flags = {4'b0, w_g | w_st};
        end
    end

    // FSM
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next = w_special ? S_DONE : S_DIV;
            S_DIV:   if (r_cnt == LAST) w_next = S_ROUND;
            S_ROUND: w_next = S_DONE;
            S_DONE:  if (r_out_valid && out_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Datapath. The result is written on entry to DONE and out_valid follows
    // one cycle later, so out_valid rises one edge after the state change.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt       <= '0;
            r_q         <= '0;
            r_rem       <= '0;
            r_my        <= '0;
            r_e         <= '0;
            r_s         <= 1'b0;
            r_rm        <= '0;
            r_result    <= '0;
            r_flags     <= '0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_s   <= w_s;
                        r_rm  <= roundmode;
                        r_rem <= {1'b0, 1'b1, x[9:0]};
                        r_my  <= {1'b1, y[9:0]};
                        r_q   <= '0;
                        r_cnt <= '0;
                        r_e   <= $signed({2'b00, x[14:10]}) - $signed({2'b00, y[14:10]})
                                 + $signed(7'(BIAS));
                        if (w_special) begin
                            r_result <= w_sp_res;
                            r_flags  <= w_sp_flags;
                        end
                    end
                end
                S_DIV: begin
                    r_cnt <= r_cnt + 4'd1;
                    if (w_ge) begin
                        r_q   <= {r_q[QBITS-2:0], 1'b1};
                        r_rem <= {w_rem_sub, 1'b0};
                    end else begin
                        r_q   <= {r_q[QBITS-2:0], 1'b0};
                        r_rem <= {r_rem[10:0], 1'b0};
                    end
                end
                S_ROUND: begin
                    r_result <= w_rnd_res;
                    r_flags  <= w_rnd_flags;
                end
                S_DONE: begin
                    if (!r_out_valid)   r_out_valid <= 1'b1;
                    else if (out_ready) r_out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign result    = r_result;
    assign flags     = r_flags;
    assign out_valid = r_out_valid;

endmodule

// File: tb/tb_fp16_div_seq.sv
// Testbench for fp16_div_seq: directed cases with literal expectations,
// then randomized operations against an arithmetic reference model.
module tb_fp16_div_seq;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] x, y, result;
    logic [1:0]  roundmode;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [4:0]  flags;

    int n_tests = 0;
    int n_fail  = 0;
    logic [20:0] exp_q[$];

    always #5 clk = ~clk;

    fp16_div_seq #(.QBITS(13), .BIAS(15)) u_dut (
        .clk(clk), .reset_n(reset_n), .x(x), .y(y), .roundmode(roundmode),
        .in_valid(in_valid), .in_ready(in_ready), .result(result), .flags(flags),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    // Reference model: returns {flags, result}
    function automatic logic [20:0] model(input logic [15:0] a, input logic [15:0] b,
                                          input logic [1:0] rm);
        int ea, eb, ma, mb, mx, my, q, r, sig, e, g, st, inc;
        bit s, az, bz, ai, bi, an, bn, asn, bsn;
        ea = a[14:10]; eb = b[14:10]; ma = a[9:0]; mb = b[9:0];
        s  = a[15] ^ b[15];
        az = (ea == 0); bz = (eb == 0);
        ai = (ea == 31) && (ma == 0); bi = (eb == 31) && (mb == 0);
        an = (ea == 31) && (ma != 0); bn = (eb == 31) && (mb != 0);
        asn = an && (ma < 512); bsn = bn && (mb < 512);
        if (an || bn)                return {(asn || bsn) ? 5'b10000 : 5'b00000, 16'h7E00};
        if ((az && bz) || (ai && bi)) return {5'b10000, 16'h7E00};
        if (ai)                      return {5'b00000, s, 15'h7C00};
        if (bz)                      return {5'b01000, s, 15'h7C00};
        if (az || bi)                return {5'b00000, s, 15'h0000};
        mx = 1024 + ma; my = 1024 + mb;
        q  = (mx * 4096) / my;
        r  = (mx * 4096) % my;
        if (q >= 4096) begin
            sig = q / 4; g = (q / 2) % 2; st = ((q % 2) != 0 || r != 0) ? 1 : 0;
            e = ea - eb + 15;
        end else begin
            sig = q / 2; g = q % 2; st = (r != 0) ? 1 : 0;
            e = ea - eb + 14;
        end
        case (rm)
            2'b00:   inc = 0;
            2'b01:   inc = (g == 1 && (st == 1 || sig % 2 == 1)) ? 1 : 0;
            2'b10:   inc = (!s && (g + st) > 0) ? 1 : 0;
            default: inc = (s && (g + st) > 0) ? 1 : 0;
        endcase
        sig = sig + inc;
        if (sig == 2048) begin sig = 1024; e = e + 1; end
        if (e >= 31) begin
            if (rm == 2'b01 || (rm == 2'b10 && !s) || (rm == 2'b11 && s))
                return {5'b00101, s, 15'h7C00};
            return {5'b00101, s, 15'h7BFF};
        end
        if (e <= 0) return {5'b00011, s, 15'h0000};
        return {4'b0000, 1'((g + st) > 0), s, 5'(e), 10'(sig - 1024)};
    endfunction

    function automatic bit is_special(input logic [15:0] a, input logic [15:0] b);
        return (a[14:10] == 5'd0) || (a[14:10] == 5'd31) ||
               (b[14:10] == 5'd0) || (b[14:10] == 5'd31);
    endfunction

    // Compare process: every cycle a result is presented it must match the
    // oldest outstanding expectation; it is retired when the consumer takes it.
    always @(negedge clk) begin
        if (reset_n && out_valid) begin
            if (exp_q.size() == 0) begin
                check("out_valid_unexpected", 32'(out_valid), 32'd0);
            end else begin
                check("result", 32'(result), 32'(exp_q[0][15:0]));
                check("flags", 32'(flags), 32'(exp_q[0][20:16]));
                if (out_ready) void'(exp_q.pop_front());
            end
        end
    end

    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic [1:0] rm,
                          input logic [20:0] expv, input int hold);
        int  lat_exp;
        bit  ok;
        lat_exp = is_special(a, b) ? 1 : 15;
        x = a; y = b; roundmode = rm; in_valid = 1'b1;
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) begin ok = 1; break; end
        end
        if (!ok) check("accept_timeout", 32'(in_ready), 32'd1);
        exp_q.push_back(expv);
        @(posedge clk); #1;
        in_valid = 1'b0;
        x = 16'($urandom); y = 16'($urandom); roundmode = 2'($urandom);
        ok = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (out_valid) begin
                check("latency", 32'(k), 32'(lat_exp));
                ok = 1;
                break;
            end
            check("in_ready_busy", 32'(in_ready), 32'd0);
        end
        if (!ok) check("out_valid_timeout", 32'(out_valid), 32'd1);
        in_valid = 1'b1;
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            check("in_ready_done", 32'(in_ready), 32'd0);
            check("out_valid_hold", 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check("out_valid_drop", 32'(out_valid), 32'd0);
        check("in_ready_after", 32'(in_ready), 32'd1);
    endtask

    task automatic directed(input logic [15:0] a, input logic [15:0] b, input logic [1:0] rm,
                            input logic [15:0] res, input logic [4:0] fl, input int hold);
        check("model_pin", 32'(model(a, b, rm)), 32'({fl, res}));
        run_op(a, b, rm, {fl, res}, hold);
    endtask

    initial begin
        logic [15:0] a, b;
        logic [1:0]  rm;
        reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        x = '0; y = '0; roundmode = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_result", 32'(result), 32'h0);
        check("rst_flags", 32'(flags), 32'h0);
        reset_n = 1'b1;

        directed(16'h3C00, 16'h4000, 2'b01, 16'h3800, 5'b00000, 0);
        directed(16'h3C00, 16'h4200, 2'b01, 16'h3555, 5'b00001, 1);
        directed(16'h3C00, 16'h4200, 2'b00, 16'h3555, 5'b00001, 0);
        directed(16'h3C00, 16'h4200, 2'b10, 16'h3556, 5'b00001, 2);
        directed(16'h3C00, 16'h4200, 2'b11, 16'h3555, 5'b00001, 0);
        directed(16'h7BFF, 16'h3800, 2'b01, 16'h7C00, 5'b00101, 0);
        directed(16'h7BFF, 16'h3800, 2'b00, 16'h7BFF, 5'b00101, 0);
        directed(16'h7BFF, 16'h3800, 2'b11, 16'h7BFF, 5'b00101, 0);
        directed(16'hFBFF, 16'h3800, 2'b11, 16'hFC00, 5'b00101, 0);
        directed(16'h3C00, 16'h0000, 2'b01, 16'h7C00, 5'b01000, 0);
        directed(16'h0000, 16'h0000, 2'b01, 16'h7E00, 5'b10000, 0);
        directed(16'hBC00, 16'h7C00, 2'b01, 16'h8000, 5'b00000, 0);
        directed(16'h7D00, 16'h3C00, 2'b01, 16'h7E00, 5'b10000, 0);
        directed(16'h0400, 16'h4000, 2'b01, 16'h0000, 5'b00011, 0);
        directed(16'h8400, 16'h4000, 2'b01, 16'h8000, 5'b00011, 0);
        directed(16'h3C00, 16'h4000, 2'b01, 16'h3800, 5'b00000, 5);

        // Reset in the middle of a division aborts it
        x = 16'h3C00; y = 16'h4200; roundmode = 2'b01; in_valid = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        check("midop_rst_out_valid", 32'(out_valid), 32'd0);
        check("midop_rst_in_ready", 32'(in_ready), 32'd1);
        check("midop_rst_result", 32'(result), 32'h0);
        exp_q.delete();
        @(posedge clk); #1;
        reset_n = 1'b1;
        directed(16'h3C00, 16'h4200, 2'b10, 16'h3556, 5'b00001, 0);

        for (int n = 0; n < 300; n++) begin
            a  = 16'($urandom);
            b  = 16'($urandom);
            rm = 2'($urandom);
            if ($urandom_range(3) == 0) begin
                a[14:10] = 5'($urandom_range(30, 24));
                b[14:10] = 5'($urandom_range(7, 1));
            end else if ($urandom_range(3) == 0) begin
                a[14:10] = 5'($urandom_range(7, 1));
                b[14:10] = 5'($urandom_range(30, 24));
            end
            run_op(a, b, rm, model(a, b, rm), int'($urandom_range(2)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
